// File: rtl/time_manager.sv
// Global emulation time keeper: reduces every clock stage's time to the minimum
// and broadcasts it as time_next under start/pause/stop run control.
module time_manager #(
    parameter int N_CLK    = 2,
    parameter int CNT_BITS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CLK*DATA_W-1:0] time_in,
    input  logic                    start,
    input  logic                    pause,
    input  logic [DATA_W-1:0]       stop_time,
    output logic [DATA_W-1:0]       time_next,
    output logic [DATA_W-1:0]       time_curr,
    output logic [CNT_BITS-1:0]     step_count,
    output logic                    running,
    output logic                    done
);
    localparam logic [DATA_W-1:0] SENTINEL = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   stop_q, stop_d;
    logic [DATA_W-1:0]   curr_q, curr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                issue;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
    endfunction

    // SENTINEL is a safe seed: no stage ever holds it, so any real time wins.
    always_comb begin
        min_d = SENTINEL;
        for (int i = 0; i < N_CLK; i++) begin
            if (time_in[i*DATA_W +: DATA_W] < min_d) begin
                min_d = time_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign issue = (state_q == RUN) && !pause && (min_q < stop_q);

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        curr_d  = curr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stop_d  = stop_time;
                end
            end
            RUN: begin
                if (min_q >= stop_q) begin
                    state_d = DONE;
                end
            end
            default: ;
        endcase
        // The bubble cycle re-issues the old minimum; it is not a new step.
        if (issue && (min_q != curr_q)) begin
            curr_d = min_q;
            cnt_d  = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            min_q   <= SENTINEL;
            stop_q  <= '0;
            curr_q  <= SENTINEL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            stop_q  <= stop_d;
            curr_q  <= curr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign time_next  = issue ? min_q : SENTINEL;
    assign time_curr  = curr_q;
    assign step_count = cnt_q;
    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_time_manager.sv
// Bench for time_manager: clock stages are modelled around the DUT and the
// issued time sequence is compared with the multiples-of-increment model.
module tb_time_manager;
    localparam int TW = 32;
    localparam logic [TW-1:0] SENT = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-clock instance
    logic          rst, start, pause;
    logic [TW-1:0] stop_time, time_next, time_curr;
    logic [31:0]   step_count;
    logic          running, done;
    logic [TW-1:0] tclk [2];
    logic [TW-1:0] inc  [2];
    logic [2*TW-1:0] time_in;
    assign time_in = {tclk[1], tclk[0]};

    time_manager #(.N_CLK(2), .CNT_BITS(32), .DATA_W(TW)) dut (
        .clk(clk), .rst(rst), .time_in(time_in), .start(start), .pause(pause),
        .stop_time(stop_time), .time_next(time_next), .time_curr(time_curr),
        .step_count(step_count), .running(running), .done(done)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) tclk[k] <= '0;
            else if (time_next == tclk[k]) tclk[k] <= tclk[k] + inc[k];
        end
    end

    // Four-clock tie instance with a 3-bit step counter
    logic          rst4, start4, pause4;
    logic [TW-1:0] stop4, tn4, tc4;
    logic [2:0]    sc4;
    logic          run4, done4;
    logic [TW-1:0] tclk4 [4];
    logic [4*TW-1:0] time_in4;
    assign time_in4 = {tclk4[3], tclk4[2], tclk4[1], tclk4[0]};

    time_manager #(.N_CLK(4), .CNT_BITS(3), .DATA_W(TW)) dut4 (
        .clk(clk), .rst(rst4), .time_in(time_in4), .start(start4), .pause(pause4),
        .stop_time(stop4), .time_next(tn4), .time_curr(tc4),
        .step_count(sc4), .running(run4), .done(done4)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst4) tclk4[k] <= '0;
            else if (tn4 == tclk4[k]) tclk4[k] <= tclk4[k] + 32'd2;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue monitor: records distinct issued times, checks stop limit and bubbles
    logic          mon_en = 1'b0;
    logic [TW-1:0] cur_stop = '0;
    logic [TW-1:0] seq [$];

    always @(negedge clk) begin
        if (mon_en && !rst && time_next != SENT) begin
            checks++;
            if (time_next >= cur_stop) begin
                errors++;
                $display("FAIL issue_below_stop: got %0d, expected below %0d", time_next, cur_stop);
            end
            if (seq.size() > 0 && seq[$] == time_next) begin
                checks++;
                if (tclk[0] == time_next || tclk[1] == time_next) begin
                    errors++;
                    $display("FAIL bubble_no_match: time %0d matched clocks %0d/%0d", time_next, tclk[0], tclk[1]);
                end
            end else begin
                seq.push_back(time_next);
            end
        end
    end

    task automatic reset_a(input int i0, input int i1);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; pause = 1'b0;
        inc[0] = TW'(i0); inc[1] = TW'(i1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        seq.delete();
    endtask

    task automatic start_a(input int st);
        cur_stop  = TW'(st);
        stop_time = TW'(st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_latency_running", running, 1);
    endtask

    task automatic wait_done_a(input bit rand_pause);
        int n = 0;
        while (!done && n < 1000) begin
            if (rand_pause) pause = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        pause = 1'b0;
        chk("done_reached", done, 1);
    endtask

    task automatic wait_curr(input int v);
        int n = 0;
        while (time_curr != TW'(v) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_time_curr", time_curr, v);
    endtask

    // Reference: the issued times are exactly the distinct multiples of either increment below stop.
    task automatic check_run(input string tag, input int i0, input int i1, input int st);
        logic [TW-1:0] exp_q [$];
        for (int t = 0; t < st; t++)
            if (t % i0 == 0 || t % i1 == 0) exp_q.push_back(TW'(t));
        chk({tag, "_nseq"}, seq.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < seq.size(); j++)
            chk({tag, "_seq"}, seq[j], exp_q[j]);
        chk({tag, "_steps"}, step_count, exp_q.size());
        chk({tag, "_curr"}, time_curr, (exp_q.size() > 0) ? exp_q[$] : SENT);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_end0"}, tclk[0], ((st + i0 - 1) / i0) * i0);
        chk({tag, "_end1"}, tclk[1], ((st + i1 - 1) / i1) * i1);
    endtask

    typedef struct {
        int            i0, i1, st, steps;
        logic [TW-1:0] curr;
        int            e0, e1;
    } vec_t;
    vec_t tbl [5];

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop_time = '0;
        inc[0] = 32'd3; inc[1] = 32'd5;
        rst4 = 1'b1; start4 = 1'b0; pause4 = 1'b0; stop4 = '0;

        tbl[0] = '{3, 5, 10, 5, 32'd9, 12, 10};
        tbl[1] = '{2, 3, 7, 5, 32'd6, 8, 9};
        tbl[2] = '{4, 4, 9, 3, 32'd8, 12, 12};
        tbl[3] = '{1, 7, 5, 5, 32'd4, 5, 7};
        tbl[4] = '{5, 5, 0, 0, SENT, 0, 0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_time_next", time_next, SENT);
        chk("rst_time_curr", time_curr, SENT);
        chk("rst_step_count", step_count, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        mon_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            reset_a(tbl[v].i0, tbl[v].i1);
            start_a(tbl[v].st);
            wait_done_a(1'b0);
            chk("tbl_steps", step_count, tbl[v].steps);
            chk("tbl_curr", time_curr, tbl[v].curr);
            chk("tbl_end0", tclk[0], tbl[v].e0);
            chk("tbl_end1", tclk[1], tbl[v].e1);
            check_run("tbl", tbl[v].i0, tbl[v].i1, tbl[v].st);
        end

        // Pause held four cycles right after time 3 is issued
        reset_a(3, 5);
        start_a(10);
        wait_curr(3);
        begin
            logic [TW-1:0] s0, s1;
            pause = 1'b1;
            s0 = tclk[0]; s1 = tclk[1];
            for (int c = 0; c < 4; c++) begin
                #1;
                chk("pause_sentinel", time_next, SENT);
                @(negedge clk);
            end
            chk("pause_frozen0", tclk[0], s0);
            chk("pause_frozen1", tclk[1], s1);
            pause = 1'b0;
        end
        wait_done_a(1'b0);
        check_run("pause", 3, 5, 10);

        // stop_time of zero: nothing issued, done two cycles after start
        reset_a(3, 5);
        start_a(0);
        chk("stop0_done_early", done, 0);
        @(negedge clk);
        chk("stop0_done", done, 1);
        chk("stop0_steps", step_count, 0);
        chk("stop0_nseq", seq.size(), 0);

        // Reset mid-run, then replay from zero
        reset_a(3, 5);
        start_a(10);
        wait_curr(5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_time_next", time_next, SENT);
        chk("midrst_steps", step_count, 0);
        chk("midrst_running", running, 0);
        chk("midrst_curr", time_curr, SENT);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        seq.delete();
        start_a(10);
        wait_done_a(1'b0);
        check_run("replay", 3, 5, 10);

        // start ignored in RUN (stop limit not resampled) and in DONE
        reset_a(3, 5);
        start_a(10);
        @(negedge clk);
        @(negedge clk);
        stop_time = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop_time = 32'd10;
        chk("start_in_run", running, 1);
        wait_done_a(1'b0);
        check_run("start_ignored", 3, 5, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_done", done, 1);
        chk("start_in_done_running", running, 0);
        @(negedge clk);
        chk("start_in_done_hold", done, 1);

        // rst and start in the same cycle: reset wins, FSM stays IDLE
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_running", running, 0);
        chk("rst_start_done", done, 0);
        @(negedge clk);
        chk("rst_start_idle", running, 0);

        // Randomized runs with random pause against the multiples model
        for (int r = 0; r < 25; r++) begin
            int i0, i1, st;
            i0 = int'($urandom_range(1, 6));
            i1 = int'($urandom_range(1, 6));
            st = int'($urandom_range(0, 30));
            reset_a(i0, i1);
            start_a(st);
            wait_done_a(1'b1);
            check_run("rand", i0, i1, st);
        end
        mon_en = 1'b0;

        // Four clocks tied at increment 2, counter saturates at 7
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        stop4 = 32'd30;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        begin
            logic [TW-1:0] seq4 [$];
            int n = 0;
            while (!done4 && n < 500) begin
                chk("tie_equal", (tclk4[0] == tclk4[1] && tclk4[1] == tclk4[2] && tclk4[2] == tclk4[3]), 1);
                if (tn4 != SENT && (seq4.size() == 0 || seq4[$] != tn4)) seq4.push_back(tn4);
                @(negedge clk);
                n++;
            end
            chk("tie_done", done4, 1);
            chk("tie_sat_steps", sc4, 7);
            chk("tie_curr", tc4, 28);
            chk("tie_end", tclk4[0], 30);
            chk("tie_nseq", seq4.size(), 15);
            for (int j = 0; j < seq4.size(); j++) chk("tie_seq", seq4[j], 2 * j);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
